instr_fetch_unit: RTL

- Prefetching instruction fetch stage sitting directly upstream of the multi-cycle controller/datapath.
- Owns the fetch PC, issues word reads to instruction memory over a req/gnt/rvalid handshake, and buffers returned words in a small in-order queue.
- Presents one instruction plus its PC to the controller with valid/ready, and accepts a redirect (branch/jump target) that flushes all speculative fetches.

---
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Prefetching instruction fetch stage: issues word reads under a credit limit,
// queues returned words in order and hands them to the controller with valid/ready.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 2;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     fetch_pc_q, fetch_pc_d;
    logic            req_q, req_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   disc_q, disc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   out_after, disc_after;

    logic [15:0]     q_data  [DEPTH];
    logic [15:0]     q_pc    [DEPTH];
    logic [15:0]     tag_mem [DEPTH];
    logic [PW-1:0]   q_rd, q_wr, tag_rd, tag_wr;

    logic            gnt_acc, rsp_drop, rsp_keep, push, pop, tag_push;

    // Next-state, credit and queue control
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;

        gnt_acc    = req_q & imem_gnt;
        rsp_drop   = imem_rvalid & (state_q == FLUSH);
        rsp_keep   = imem_rvalid & (state_q == RUN);
        push       = rsp_keep & ~redirect;
        pop        = (cnt_q != '0) & instr_ready & ~redirect;
        tag_push   = gnt_acc & ~redirect;

        out_after  = out_q + CW'(gnt_acc) - CW'(rsp_keep);
        disc_after = disc_q - CW'(rsp_drop);

        out_d      = out_after;
        disc_d     = disc_after;
        cnt_d      = cnt_q + CW'(push) - CW'(pop);

        // Redirect turns every in-flight read into a discard credit
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            disc_d     = disc_after + out_after;
            out_d      = '0;
            cnt_d      = '0;
        end else if (gnt_acc) begin
            fetch_pc_d = fetch_pc_q + 16'd1;
        end

        // Hold an ungranted request; otherwise issue while credits remain
        if (req_q && !imem_gnt && !redirect) begin
            req_d = 1'b1;
        end else begin
            req_d = (SW'(cnt_d) + SW'(out_d) + SW'(disc_d)) < SW'(DEPTH);
        end

        unique case (state_q)
            RUN: begin
                if (redirect && (disc_d != '0)) state_d = FLUSH;
            end
            FLUSH: begin
                if (disc_d == '0) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            out_q      <= '0;
            disc_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            cnt_q      <= cnt_d;
        end
    end

    // Instruction queue and issued-address tag FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_data[i]  <= '0;
                q_pc[i]    <= '0;
                tag_mem[i] <= '0;
            end
            q_rd   <= '0;
            q_wr   <= '0;
            tag_rd <= '0;
            tag_wr <= '0;
        end else if (redirect) begin
            q_rd   <= '0;
            q_wr   <= '0;
            tag_rd <= '0;
            tag_wr <= '0;
        end else begin
            if (push) begin
                q_data[q_wr] <= imem_rdata;
                q_pc[q_wr]   <= tag_mem[tag_rd];
                q_wr         <= q_wr + PW'(1);
            end
            if (pop) begin
                q_rd <= q_rd + PW'(1);
            end
            if (tag_push) begin
                tag_mem[tag_wr] <= fetch_pc_q;
                tag_wr          <= tag_wr + PW'(1);
            end
            if (rsp_keep) begin
                tag_rd <= tag_rd + PW'(1);
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (cnt_q != '0);
    assign instr       = q_data[q_rd];
    assign instr_pc    = q_pc[q_rd];

endmodule
